// File: rtl/store_buffer.sv
// store_buffer: a circular FIFO of pending stores that sits between the Memory
// stage and the data memory.
//  - Stores are enqueued when MemWriteM=1 and StallM=0.
//  - The buffer drains in acceptance order through a BufWe/BufAck handshake.
//  - Load/store address matching uses only the word address bits [31:2].
// Optional feature macro: STORE_BUF_FWD_EN.
//  - Defined: a load that hits a buffered store takes the data of the youngest
//    matching entry through FwdHitM/FwdDataM.
//  - Undefined (default): such a load raises StallM until the matching entries
//    have drained.
// BufWe/BufAdr/BufWd are registered. They show a preview of the head entry as
// it will be after the coming edge.
module store_buffer #(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   MemWriteM,
    input  logic                   MemReadM,
    input  logic [31:0]            DataAdrM,
    input  logic [31:0]            WriteDataM,
    output logic                   StallM,
    output logic                   FwdHitM,
    output logic [31:0]            FwdDataM,
    output logic                   BufWe,
    output logic [31:0]            BufAdr,
    output logic [31:0]            BufWd,
    input  logic                   BufAck,
    output logic [$clog2(DEPTH):0] Count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] head_ptr_r;
    logic [PTR_W-1:0] tail_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic [31:0]      adr_mem_r  [DEPTH];
    logic [31:0]      data_mem_r [DEPTH];
    logic             buf_we_r;
    logic [31:0]      buf_adr_r;
    logic [31:0]      buf_wd_r;

    logic [PTR_W-1:0] head_next_s;
    logic [PTR_W-1:0] tail_next_s;
    logic [CNT_W-1:0] count_next_s;
    logic             buf_we_next_s;
    logic [31:0]      buf_adr_next_s;
    logic [31:0]      buf_wd_next_s;
    logic             empty_s;
    logic             full_s;
    logic             load_s;
    logic             enq_s;
    logic             pop_s;
    logic             store_stall_s;
    logic             load_stall_s;
    logic             match_s;
    logic             entry_hit_s;
    logic [31:0]      match_data_s;
    logic [PTR_W-1:0] fwd_idx_s;

    // Occupancy flags and the store/pop handshake qualifiers.
    always_comb begin
        empty_s       = (count_r == {CNT_W{1'b0}});
        full_s        = (count_r == CNT_W'(DEPTH));
        load_s        = MemReadM & ~MemWriteM;
        store_stall_s = MemWriteM & full_s;
        pop_s         = ~empty_s & BufAck;
    end

    // Scan the entries from oldest to youngest. A later hit overrides an
    // earlier one, so the youngest matching word address wins.
    always_comb begin
        match_s      = 1'b0;
        match_data_s = 32'h0000_0000;
        entry_hit_s  = 1'b0;
        fwd_idx_s    = head_ptr_r;
        for (int i = 0; i < DEPTH; i++) begin
            fwd_idx_s    = head_ptr_r + PTR_W'(i);
            entry_hit_s  = (CNT_W'(i) < count_r) &&
                           (adr_mem_r[fwd_idx_s][31:2] == DataAdrM[31:2]);
            match_s      = match_s | entry_hit_s;
            match_data_s = entry_hit_s ? data_mem_r[fwd_idx_s] : match_data_s;
        end
    end

    // Load hazard: either forward the youngest match or stall until it drains.
    always_comb begin
`ifdef STORE_BUF_FWD_EN
        load_stall_s = 1'b0;
        if (load_s && match_s) begin
            FwdHitM  = 1'b1;
            FwdDataM = match_data_s;
        end else begin
            FwdHitM  = 1'b0;
            FwdDataM = 32'h0000_0000;
        end
`else
        FwdHitM      = 1'b0;
        FwdDataM     = 32'h0000_0000;
        load_stall_s = load_s & match_s;
`endif
    end

    // Stall and enqueue decision. A pop on the same edge does not free a slot
    // for a store that arrives while the buffer is full.
    always_comb begin
        StallM = store_stall_s | load_stall_s;
        enq_s  = MemWriteM & ~StallM;
    end

    // Next pointer and occupancy values. Pointers wrap naturally because DEPTH
    // is a power of two.
    always_comb begin
        if (pop_s) begin
            head_next_s = head_ptr_r + PTR_W'(1);
        end else begin
            head_next_s = head_ptr_r;
        end
        if (enq_s) begin
            tail_next_s = tail_ptr_r + PTR_W'(1);
        end else begin
            tail_next_s = tail_ptr_r;
        end
        case ({enq_s, pop_s})
            2'b10:   count_next_s = count_r + CNT_W'(1);
            2'b01:   count_next_s = count_r - CNT_W'(1);
            default: count_next_s = count_r;
        endcase
    end

    // Preview of the head entry after this edge, for the registered memory
    // port. The incoming store becomes the head when the buffer is empty, or
    // when its only entry pops on the same edge.
    always_comb begin
        buf_we_next_s = (count_next_s != {CNT_W{1'b0}});
        if (!buf_we_next_s) begin
            buf_adr_next_s = 32'h0000_0000;
            buf_wd_next_s  = 32'h0000_0000;
        end else if (empty_s || (pop_s && (count_r == CNT_W'(1)))) begin
            buf_adr_next_s = DataAdrM;
            buf_wd_next_s  = WriteDataM;
        end else begin
            buf_adr_next_s = adr_mem_r[head_next_s];
            buf_wd_next_s  = data_mem_r[head_next_s];
        end
    end

    // Pointer, count and memory-port state. Reset clears it at once and drops
    // every pending store.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_ptr_r <= {PTR_W{1'b0}};
            tail_ptr_r <= {PTR_W{1'b0}};
            count_r    <= {CNT_W{1'b0}};
            buf_we_r   <= 1'b0;
            buf_adr_r  <= 32'h0000_0000;
            buf_wd_r   <= 32'h0000_0000;
        end else begin
            head_ptr_r <= head_next_s;
            tail_ptr_r <= tail_next_s;
            count_r    <= count_next_s;
            buf_we_r   <= buf_we_next_s;
            buf_adr_r  <= buf_adr_next_s;
            buf_wd_r   <= buf_wd_next_s;
        end
    end

    // Storage array. The count qualifies every entry, so it needs no reset.
    always_ff @(posedge clk) begin
        if (enq_s) begin
            adr_mem_r[tail_ptr_r]  <= DataAdrM;
            data_mem_r[tail_ptr_r] <= WriteDataM;
        end
    end

    assign BufWe  = buf_we_r;
    assign BufAdr = buf_adr_r;
    assign BufWd  = buf_wd_r;
    assign Count  = count_r;

endmodule

// File: tb/tb_store_buffer.sv
// Testbench for store_buffer (DEPTH=4).
// A cycle table checks the stall, write-enable and count behaviour. A
// scoreboard queue checks the order and contents of every memory write. Short
// hand-written sequences cover load hazards, reset mid-drain and pointer wrap.
module tb_store_buffer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemWriteM;
    logic        MemReadM;
    logic [31:0] DataAdrM;
    logic [31:0] WriteDataM;
    logic        StallM;
    logic        FwdHitM;
    logic [31:0] FwdDataM;
    logic        BufWe;
    logic [31:0] BufAdr;
    logic [31:0] BufWd;
    logic        BufAck;
    logic [2:0]  Count;

    store_buffer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .MemWriteM(MemWriteM), .MemReadM(MemReadM),
        .DataAdrM(DataAdrM), .WriteDataM(WriteDataM), .StallM(StallM),
        .FwdHitM(FwdHitM), .FwdDataM(FwdDataM), .BufWe(BufWe), .BufAdr(BufAdr),
        .BufWd(BufWd), .BufAck(BufAck), .Count(Count)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int writesSeen = 0;

    typedef struct packed {
        logic [31:0] adr;
        logic [31:0] wd;
    } st_t;
    st_t sbQ[$];
    st_t sbExp;

    typedef struct {
        logic        we;
        logic        re;
        logic [31:0] adr;
        logic [31:0] wd;
        logic        ack;
        logic        expStall;
        logic        expHit;
        logic        expBufWe;
        logic [2:0]  expCount;
    } vec_t;
    vec_t vecs[17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic setIn(input logic we, input logic re, input logic [31:0] adr,
                         input logic [31:0] wd, input logic ack);
        MemWriteM  = we;
        MemReadM   = re;
        DataAdrM   = adr;
        WriteDataM = wd;
        BufAck     = ack;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: check each write taken by memory, then record each store
    // accepted at the coming edge. Inputs are stable at the falling edge.
    always @(negedge clk) begin
        if (reset) begin
            if (BufWe && BufAck) begin
                writesSeen++;
                if (sbQ.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_write actual=0x%0h/0x%0h expected=none", BufAdr, BufWd);
                end else begin
                    sbExp = sbQ.pop_front();
                    check("drain_adr", BufAdr, sbExp.adr);
                    check("drain_wd", BufWd, sbExp.wd);
                end
            end
            if (MemWriteM && !StallM) begin
                sbQ.push_back({DataAdrM, WriteDataM});
            end
        end
    end

    initial begin : main
        int idx;
        int base;
        logic [31:0] wdat;

        //          we    re    adr         wd          ack   stall hit   bufwe cnt
        vecs[0]  = '{1'b1, 1'b0, 32'h64,     32'h7,      1'b1, 1'b0, 1'b0, 1'b0, 3'd0};
        vecs[1]  = '{1'b0, 1'b0, 32'h0,      32'h0,      1'b1, 1'b0, 1'b0, 1'b1, 3'd1};
        vecs[2]  = '{1'b0, 1'b0, 32'h0,      32'h0,      1'b0, 1'b0, 1'b0, 1'b0, 3'd0};
        vecs[3]  = '{1'b1, 1'b0, 32'h100,    32'h11,     1'b0, 1'b0, 1'b0, 1'b0, 3'd0};
        vecs[4]  = '{1'b1, 1'b0, 32'h104,    32'h12,     1'b0, 1'b0, 1'b0, 1'b1, 3'd1};
        vecs[5]  = '{1'b1, 1'b0, 32'h108,    32'h13,     1'b0, 1'b0, 1'b0, 1'b1, 3'd2};
        vecs[6]  = '{1'b1, 1'b0, 32'h10C,    32'h14,     1'b0, 1'b0, 1'b0, 1'b1, 3'd3};
        vecs[7]  = '{1'b1, 1'b0, 32'h110,    32'h15,     1'b0, 1'b1, 1'b0, 1'b1, 3'd4};
        vecs[8]  = '{1'b1, 1'b0, 32'h110,    32'h15,     1'b0, 1'b1, 1'b0, 1'b1, 3'd4};
        vecs[9]  = '{1'b1, 1'b0, 32'h110,    32'h15,     1'b1, 1'b1, 1'b0, 1'b1, 3'd4};
        vecs[10] = '{1'b1, 1'b0, 32'h110,    32'h15,     1'b0, 1'b0, 1'b0, 1'b1, 3'd3};
        vecs[11] = '{1'b0, 1'b0, 32'h0,      32'h0,      1'b1, 1'b0, 1'b0, 1'b1, 3'd4};
        vecs[12] = '{1'b0, 1'b0, 32'h0,      32'h0,      1'b1, 1'b0, 1'b0, 1'b1, 3'd3};
        vecs[13] = '{1'b0, 1'b0, 32'h0,      32'h0,      1'b1, 1'b0, 1'b0, 1'b1, 3'd2};
        vecs[14] = '{1'b0, 1'b0, 32'h0,      32'h0,      1'b1, 1'b0, 1'b0, 1'b1, 3'd1};
        vecs[15] = '{1'b0, 1'b0, 32'h0,      32'h0,      1'b0, 1'b0, 1'b0, 1'b0, 3'd0};
        vecs[16] = '{1'b0, 1'b1, 32'h500,    32'h0,      1'b0, 1'b0, 1'b0, 1'b0, 3'd0};

        reset = 1'b0;
        setIn(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        repeat (2) @(posedge clk);
        #3;
        check("rst_count", 32'(Count), 32'd0);
        check("rst_bufwe", 32'(BufWe), 32'd0);
        check("rst_stall", 32'(StallM), 32'd0);
        check("rst_bufadr", BufAdr, 32'h0);
        reset = 1'b1;
        tick();

        // Cycle table: single store, fill to full, store while full, drain.
        for (int i = 0; i < 17; i++) begin
            setIn(vecs[i].we, vecs[i].re, vecs[i].adr, vecs[i].wd, vecs[i].ack);
            #1;
            check($sformatf("vec%0d_stall", i), 32'(StallM), 32'(vecs[i].expStall));
            check($sformatf("vec%0d_hit", i), 32'(FwdHitM), 32'(vecs[i].expHit));
            check($sformatf("vec%0d_bufwe", i), 32'(BufWe), 32'(vecs[i].expBufWe));
            check($sformatf("vec%0d_count", i), 32'(Count), 32'(vecs[i].expCount));
            if (!vecs[i].expBufWe) begin
                check($sformatf("vec%0d_bufadr_idle", i), BufAdr, 32'h0);
            end
            tick();
        end

        // Load hazard on two buffered stores to the same word.
        setIn(1'b1, 1'b0, 32'h20, 32'hA, 1'b0); tick();
        setIn(1'b1, 1'b0, 32'h20, 32'hB, 1'b0); tick();
        setIn(1'b0, 1'b1, 32'h22, 32'h0, 1'b0); #1;
`ifdef STORE_BUF_FWD_EN
        check("ld_hit", 32'(FwdHitM), 32'd1);
        check("ld_data", FwdDataM, 32'hB);
        check("ld_stall", 32'(StallM), 32'd0);
`else
        check("ld_stall", 32'(StallM), 32'd1);
        check("ld_hit", 32'(FwdHitM), 32'd0);
        check("ld_data", FwdDataM, 32'h0);
`endif
        check("ld_count", 32'(Count), 32'd2);
        tick();
        // Read together with write is a store: no load stall, no forward.
        setIn(1'b1, 1'b1, 32'h30, 32'hC, 1'b0); #1;
        check("rw_stall", 32'(StallM), 32'd0);
        check("rw_hit", 32'(FwdHitM), 32'd0);
        tick();
        check("rw_count", 32'(Count), 32'd3);
        setIn(1'b0, 1'b1, 32'h22, 32'h0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            #1;
`ifdef STORE_BUF_FWD_EN
            check($sformatf("ld_drain%0d_hit", k), 32'(FwdHitM), (k < 2) ? 32'd1 : 32'd0);
            check($sformatf("ld_drain%0d_data", k), FwdDataM, (k < 2) ? 32'hB : 32'h0);
            check($sformatf("ld_drain%0d_stall", k), 32'(StallM), 32'd0);
`else
            check($sformatf("ld_drain%0d_stall", k), 32'(StallM), (k < 2) ? 32'd1 : 32'd0);
`endif
            check($sformatf("ld_drain%0d_count", k), 32'(Count), 32'(3 - k));
            tick();
        end
        setIn(1'b0, 1'b0, 32'h0, 32'h0, 1'b0); tick();
        check("ld_empty", 32'(Count), 32'd0);

        // Reset in the middle of a cycle with three stores pending.
        setIn(1'b1, 1'b0, 32'h200, 32'h21, 1'b0); tick();
        setIn(1'b1, 1'b0, 32'h204, 32'h22, 1'b0); tick();
        setIn(1'b1, 1'b0, 32'h208, 32'h23, 1'b0); tick();
        check("pre_rst_count", 32'(Count), 32'd3);
        setIn(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        #2;
        reset = 1'b0;
        sbQ.delete();
        #1;
        check("midrst_bufwe", 32'(BufWe), 32'd0);
        check("midrst_count", 32'(Count), 32'd0);
        check("midrst_bufadr", BufAdr, 32'h0);
        check("midrst_bufwd", BufWd, 32'h0);
        check("midrst_stall", 32'(StallM), 32'd0);
        tick();
        tick();
        base = writesSeen;
        setIn(1'b1, 1'b0, 32'h300, 32'h33, 1'b0);
        #2;
        reset = 1'b1;
        tick();
        check("post_rst_count", 32'(Count), 32'd1);
        check("post_rst_bufadr", BufAdr, 32'h300);
        setIn(1'b0, 1'b0, 32'h0, 32'h0, 1'b1); tick();
        setIn(1'b0, 1'b0, 32'h0, 32'h0, 1'b0); tick();
        check("post_rst_writes", 32'(writesSeen - base), 32'd1);

        // Pointer wrap: ten stores against an alternating acknowledge.
        base = writesSeen;
        idx  = 0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            if (idx >= 10 && Count == 3'd0) break;
            wdat = $urandom;
            setIn(idx < 10, 1'b0, 32'h4000 + 32'(idx) * 32'd4, wdat, cyc[0]);
            #1;
            if (MemWriteM && !StallM) idx++;
            tick();
        end
        setIn(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        check("wrap_issued", 32'(idx), 32'd10);
        check("wrap_count", 32'(Count), 32'd0);
        check("wrap_writes", 32'(writesSeen - base), 32'd10);
        tick();

        check("sb_empty", 32'(sbQ.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
